// File: rtl/mcore_pkg.sv
// Shared types and constants for the mcore memory-port arbiter and its tag FIFO.
package mcore_pkg;

    localparam int MCORE_MEM_PORTS = 3;
    localparam int ARB_ID_W        = $clog2(MCORE_MEM_PORTS);

    typedef logic [ARB_ID_W-1:0] arb_id_t;

    localparam arb_id_t PORT_SRC  = arb_id_t'(0);
    localparam arb_id_t PORT_FB   = arb_id_t'(1);
    localparam arb_id_t PORT_PLUT = arb_id_t'(2);

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mcore_tag_fifo.sv
// In-order FIFO of granted port IDs with a fall-through head; one cycle push-to-visible.
// Pushes while full and pops while empty are ignored; simultaneous push/pop keeps count.
module mcore_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mcore_mem_arb.sv
// Round-robin arbiter for the mcore memory port: zero-latency request path, responses routed in order.
// A stalled request is locked until granted; no new grant while MAX_OUTSTANDING responses are pending.
module mcore_mem_arb
    import mcore_pkg::*;
#(
    parameter int N_PORTS         = 3,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [N_PORTS-1:0]                s_req,
    input  logic [N_PORTS*ADDR_WIDTH-1:0]     s_addr,
    input  logic [N_PORTS-1:0]                s_we,
    input  logic [N_PORTS*DATA_WIDTH-1:0]     s_wdata,
    input  logic [N_PORTS*DATA_WIDTH/8-1:0]   s_be,
    output logic [N_PORTS-1:0]                s_gnt,
    output logic [N_PORTS-1:0]                s_rsp_valid,
    output logic [DATA_WIDTH-1:0]             s_rsp_rdata,
    output logic                              s_rsp_error,
    output logic                              mem_req,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic                              mem_we,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    output logic [DATA_WIDTH/8-1:0]           mem_be,
    input  logic                              mem_gnt,
    input  logic                              mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]             mem_rsp_rdata,
    input  logic                              mem_rsp_error,
    output logic                              busy,
    output logic                              err_unexpected_rsp
);

    localparam int ID_W  = $clog2(N_PORTS);
    localparam int BE_W  = DATA_WIDTH/8;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  locked_id;
    logic [ID_W-1:0]  locked_id_nxt;
    logic [ID_W-1:0]  rr_sel;
    logic [ID_W-1:0]  sel;
    logic [ID_W-1:0]  head_id;
    logic             rr_found;
    int               rr_idx;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             grant;
    logic             pop;

    always_comb begin
        rr_sel   = rr_ptr;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int k = 0; k < N_PORTS; k++) begin
            rr_idx = (int'(rr_ptr) + k) % N_PORTS;
            if (!rr_found && s_req[rr_idx[ID_W-1:0]]) begin
                rr_found = 1'b1;
                rr_sel   = rr_idx[ID_W-1:0];
            end
        end
    end

    assign sel     = (state == ARB_LOCKED) ? locked_id : rr_sel;
    assign mem_req = s_req[sel] & ~fifo_full & ~areset;
    assign grant   = mem_req & mem_gnt;
    assign pop     = mem_rsp_valid & ~fifo_empty & ~areset;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_be    = '0;
        if (mem_req) begin
            mem_addr  = s_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_we    = s_we[sel];
            mem_wdata = s_wdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
            mem_be    = s_be[int'(sel)*BE_W +: BE_W];
        end
    end

    always_comb begin
        s_gnt       = '0;
        s_rsp_valid = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            s_gnt[i]       = grant && (sel == ID_W'(i));
            s_rsp_valid[i] = pop && (head_id == ID_W'(i));
        end
    end

    assign s_rsp_rdata = areset ? '0 : mem_rsp_rdata;
    assign s_rsp_error = ~areset & mem_rsp_error;
    assign busy        = ~areset & ((fifo_count != '0) | (|s_req));

    // Lock holds the memory-side request stable while memory stalls it.
    always_comb begin
        state_nxt     = state;
        locked_id_nxt = locked_id;
        case (state)
            ARB_OPEN: begin
                if (mem_req && !mem_gnt) begin
                    state_nxt     = ARB_LOCKED;
                    locked_id_nxt = sel;
                end
            end
            ARB_LOCKED: begin
                if (grant) state_nxt = ARB_OPEN;
            end
            default: state_nxt = ARB_OPEN;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= ARB_OPEN;
            locked_id <= '0;
        end else begin
            state     <= state_nxt;
            locked_id <= locked_id_nxt;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rr_ptr             <= '0;
            err_unexpected_rsp <= 1'b0;
        end else begin
            if (grant) rr_ptr <= (sel == ID_W'(N_PORTS-1)) ? '0 : sel + 1'b1;
            if (mem_rsp_valid && fifo_empty) err_unexpected_rsp <= 1'b1;
        end
    end

    mcore_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_W)
    ) u_tag_fifo (
        .clk       (aclk),
        .rst       (areset),
        .push      (grant),
        .push_data (sel),
        .pop       (pop),
        .head      (head_id),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_mcore_mem_arb.sv
// Randomized bench for mcore_mem_arb against a queue-based reference of arbitration and response routing.
module tb_mcore_mem_arb;
    import mcore_pkg::*;

    localparam int N    = 3;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int MAXO = 4;
    localparam int BW   = DW/8;

    logic            aclk = 1'b0;
    logic            areset;
    logic [N-1:0]    s_req, s_we, s_gnt, s_rsp_valid;
    logic [N*AW-1:0] s_addr;
    logic [N*DW-1:0] s_wdata;
    logic [N*BW-1:0] s_be;
    logic [DW-1:0]   s_rsp_rdata;
    logic            s_rsp_error;
    logic            mem_req, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [BW-1:0]   mem_be;
    logic            mem_gnt, mem_rsp_valid, mem_rsp_error;
    logic [DW-1:0]   mem_rsp_rdata;
    logic            busy, err_unexpected_rsp;

    mcore_mem_arb #(
        .N_PORTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata), .s_be(s_be),
        .s_gnt(s_gnt), .s_rsp_valid(s_rsp_valid), .s_rsp_rdata(s_rsp_rdata), .s_rsp_error(s_rsp_error),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .mem_rsp_error(mem_rsp_error), .busy(busy), .err_unexpected_rsp(err_unexpected_rsp)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester-side state: one held request per port until granted.
    bit            pend    [N];
    logic [AW-1:0] p_addr  [N];
    logic          p_we    [N];
    logic [DW-1:0] p_wdata [N];
    logic [BW-1:0] p_be    [N];

    // Reference: round-robin pointer, stall lock, queue of outstanding port IDs.
    int rr;
    bit locked;
    int locked_id;
    int outst[$];
    bit err_m;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic          err;
    } mrsp_t;
    mrsp_t memq[$];
    int    last_due = 0;
    int    cyc = 0;

    int req_pct = 50;
    int gnt_pct = 70;
    int max_lat = 4;
    bit allow_new = 1'b1;

    function automatic bit any_pend();
        for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic apply_ports();
        for (int i = 0; i < N; i++) begin
            s_req[i]              = pend[i];
            s_we[i]               = p_we[i];
            s_addr[i*AW +: AW]    = p_addr[i];
            s_wdata[i*DW +: DW]   = p_wdata[i];
            s_be[i*BW +: BW]      = p_be[i];
        end
    endtask

    task automatic clear_model();
        outst.delete();
        memq.delete();
        rr = 0;
        locked = 1'b0;
        locked_id = 0;
        err_m = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
    endtask

    task automatic run_cycle(input bit inject);
        int            sel;
        int            due;
        bit            ereq, egnt, rsp;
        logic [DW-1:0] rdat;
        logic          rerr;
        logic [N-1:0]  exp_gnt, exp_rsp;
        mrsp_t         m;

        @(negedge aclk);
        if (allow_new) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && int'($urandom_range(99)) < req_pct) begin
                    pend[i]    = 1'b1;
                    p_addr[i]  = $urandom;
                    p_we[i]    = 1'($urandom);
                    p_wdata[i] = $urandom;
                    p_be[i]    = BW'($urandom);
                end
            end
        end
        rsp = 1'b0; rdat = '0; rerr = 1'b0;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            rsp = 1'b1; rdat = memq[0].data; rerr = memq[0].err;
            void'(memq.pop_front());
        end else if (inject && memq.size() == 0) begin
            rsp = 1'b1; rdat = $urandom;
        end
        mem_rsp_valid = rsp;
        mem_rsp_rdata = rdat;
        mem_rsp_error = rerr;
        mem_gnt       = (int'($urandom_range(99)) < gnt_pct);
        apply_ports();
        #2;

        sel = -1;
        if (locked) sel = locked_id;
        else for (int k = 0; k < N; k++) if (sel < 0 && pend[(rr + k) % N]) sel = (rr + k) % N;
        ereq    = (sel >= 0) && pend[sel] && (outst.size() < MAXO);
        egnt    = ereq && mem_gnt;
        exp_gnt = egnt ? N'(1 << sel) : '0;
        exp_rsp = (rsp && outst.size() > 0) ? N'(1 << outst[0]) : '0;

        check_eq("mem_req", 64'(mem_req), 64'(ereq));
        check_eq("s_gnt", 64'(s_gnt), 64'(exp_gnt));
        check_eq("s_rsp_valid", 64'(s_rsp_valid), 64'(exp_rsp));
        check_eq("err_unexpected_rsp", 64'(err_unexpected_rsp), 64'(err_m));
        check_eq("busy", 64'(busy), 64'((outst.size() > 0) || any_pend()));
        if (ereq) begin
            check_eq("mem_addr", 64'(mem_addr), 64'(p_addr[sel]));
            check_eq("mem_we", 64'(mem_we), 64'(p_we[sel]));
            check_eq("mem_wdata", 64'(mem_wdata), 64'(p_wdata[sel]));
            check_eq("mem_be", 64'(mem_be), 64'(p_be[sel]));
        end else if (!any_pend()) begin
            check_eq("mem_addr_idle", 64'(mem_addr), 64'd0);
        end
        if (rsp) begin
            check_eq("s_rsp_rdata", 64'(s_rsp_rdata), 64'(rdat));
            check_eq("s_rsp_error", 64'(s_rsp_error), 64'(rerr));
        end

        if (rsp) begin
            if (outst.size() > 0) void'(outst.pop_front());
            else err_m = 1'b1;
        end
        if (egnt) begin
            outst.push_back(sel);
            pend[sel] = 1'b0;
            rr        = (sel + 1) % N;
            locked    = 1'b0;
            due       = cyc + int'($urandom_range(max_lat, 1));
            if (due <= last_due) due = last_due + 1;
            last_due  = due;
            m.due     = due;
            m.data    = p_addr[sel] ^ 32'h5A5A_C3C3;
            m.err     = ($urandom_range(7) == 0);
            memq.push_back(m);
        end else if (ereq) begin
            locked    = 1'b1;
            locked_id = sel;
        end
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_mem_req"}, 64'(mem_req), 64'd0);
        check_eq({tag, "_s_gnt"}, 64'(s_gnt), 64'd0);
        check_eq({tag, "_s_rsp_valid"}, 64'(s_rsp_valid), 64'd0);
        check_eq({tag, "_s_rsp_rdata"}, 64'(s_rsp_rdata), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_err"}, 64'(err_unexpected_rsp), 64'd0);
        check_eq({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    endtask

    task automatic drain(input string tag);
        int t;
        allow_new = 1'b0;
        gnt_pct   = 100;
        t = 0;
        while (t < 400 && (any_pend() || memq.size() > 0)) begin
            run_cycle(1'b0);
            t++;
        end
        check_eq({tag, "_drained"}, 64'(any_pend() || memq.size() > 0), 64'd0);
        allow_new = 1'b1;
    endtask

    initial begin
        areset = 1'b1;
        mem_gnt = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; mem_rsp_error = 1'b0;
        clear_model();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1; p_addr[i] = 32'h1000 * (i + 1); p_we[i] = 1'b0;
            p_wdata[i] = '0; p_be[i] = '1;
        end
        apply_ports();
        #12;
        check_reset_outputs("reset");
        @(negedge aclk);
        clear_model();
        apply_ports();
        areset = 1'b0;

        req_pct = 50; gnt_pct = 70; max_lat = 4;
        repeat (300) run_cycle(1'b0);

        req_pct = 100; gnt_pct = 100; max_lat = 20;
        repeat (150) run_cycle(1'b0);

        req_pct = 40; gnt_pct = 30; max_lat = 6;
        repeat (200) run_cycle(1'b0);
        drain("d1");

        run_cycle(1'b1);
        repeat (3) run_cycle(1'b0);

        req_pct = 80; gnt_pct = 100; max_lat = 12;
        repeat (20) run_cycle(1'b0);
        @(negedge aclk);
        #1;
        areset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        clear_model();
        mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; mem_rsp_error = 1'b0; mem_gnt = 1'b0;
        apply_ports();
        @(negedge aclk);
        areset = 1'b0;

        pend[0] = 1'b1; p_addr[0] = 32'h0000_1000; p_we[0] = 1'b0; p_wdata[0] = '0; p_be[0] = '1;
        pend[1] = 1'b1; p_addr[1] = 32'h0000_2000; p_we[1] = 1'b1; p_wdata[1] = 32'hCAFE_0001; p_be[1] = 4'h3;
        allow_new = 1'b0;
        repeat (8) run_cycle(1'b0);
        allow_new = 1'b1;

        req_pct = 60; gnt_pct = 60; max_lat = 8;
        repeat (250) run_cycle(1'b0);
        drain("d2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
